// File: rtl/idu_q_if.sv
// idu_q_if: handshake and data bundle between IFU, the queued decode stage
// and EXU.
//   Upstream   : i_pre_valid / o_pre_ready, i_pc, i_instr
//   Control    : i_flush
//   Downstream : o_post_valid / i_post_ready, o_pc and the decoded fields
//   Status     : o_count (FIFO occupancy, output register not included)
// The slave modport is the decode stage; master is the environment driving it.
interface idu_q_if #(
  parameter int INS_WIDTH = 32,
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
);
  logic                 i_pre_valid;
  logic                 o_pre_ready;
  logic [PC_WIDTH-1:0]  i_pc;
  logic [INS_WIDTH-1:0] i_instr;
  logic                 i_flush;
  logic                 o_post_valid;
  logic                 i_post_ready;
  logic [PC_WIDTH-1:0]  o_pc;
  logic [4:0]           o_rdid;
  logic [4:0]           o_rs1id;
  logic [4:0]           o_rs2id;
  logic                 o_rdwen;
  logic [31:0]          o_imm;
  logic [9:0]           o_cls;
  logic [2:0]           o_funct3;
  logic                 o_f7b5;
  logic                 o_ecall;
  logic                 o_mret;
  logic                 o_illegal;
  logic [CNT_W-1:0]     o_count;

  modport slave (
    input  i_pre_valid, i_pc, i_instr, i_flush, i_post_ready,
    output o_pre_ready, o_post_valid, o_pc, o_rdid, o_rs1id, o_rs2id,
           o_rdwen, o_imm, o_cls, o_funct3, o_f7b5, o_ecall, o_mret,
           o_illegal, o_count
  );

  modport master (
    output i_pre_valid, i_pc, i_instr, i_flush, i_post_ready,
    input  o_pre_ready, o_post_valid, o_pc, o_rdid, o_rs1id, o_rs2id,
           o_rdwen, o_imm, o_cls, o_funct3, o_f7b5, o_ecall, o_mret,
           o_illegal, o_count
  );
endinterface

// File: rtl/idu_q.sv
// idu_q: queued, registered RV32I instruction-decode stage.
// {pc, instr} pairs are buffered in a DEPTH-entry FIFO; the FIFO head is
// decoded combinationally and captured into an elastic output register on pop.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : idu_q_if.slave (upstream handshake, flush, downstream handshake,
//            decoded fields, FIFO occupancy)
module idu_q #(
  parameter int INS_WIDTH = 32,
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic   i_clk,
  input  logic   i_rst,
  idu_q_if.slave bus
);
  localparam int               AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rdid;
    logic [4:0]          rs1id;
    logic [4:0]          rs2id;
    logic                rdwen;
    logic [31:0]         imm;
    logic [9:0]          cls;
    logic [2:0]          funct3;
    logic                f7b5;
    logic                ecall;
    logic                mret;
    logic                illegal;
  } dec_t;

  logic [PC_WIDTH-1:0]  pc_mem  [DEPTH];
  logic [INS_WIDTH-1:0] ins_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  dec_t             out_q, out_d;
  dec_t             dec;
  logic             pre_ready, push, pop;
  logic [INS_WIDTH-1:0] ins;

  // Ready comes from registered occupancy only, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign pre_ready = (cnt_q != FULL);
  assign push      = bus.i_pre_valid & pre_ready & ~bus.i_flush;
  assign pop       = (cnt_q != '0) & (~vld_q | bus.i_post_ready) & ~bus.i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= bus.i_pc;
      ins_mem[wr_ptr_q] <= bus.i_instr;
    end
  end

  assign ins = ins_mem[rd_ptr_q];

  always_comb begin
    dec         = '0;
    dec.pc      = pc_mem[rd_ptr_q];
    dec.rdid    = ins[11:7];
    dec.rs1id   = ins[19:15];
    dec.rs2id   = ins[24:20];
    dec.funct3  = ins[14:12];
    dec.f7b5    = ins[30];
    case (ins[6:0])
      OPC_OP: begin
        dec.cls[0] = 1'b1;
        dec.rdwen  = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        dec.cls[1] = (ins[6:0] == OPC_OPIMM);
        dec.cls[2] = (ins[6:0] == OPC_LOAD);
        dec.cls[6] = (ins[6:0] == OPC_JALR);
        dec.rdwen  = 1'b1;
        dec.rs2id  = '0;
        dec.imm    = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        dec.cls[3] = 1'b1;
        dec.rdid   = '0;
        dec.imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        dec.cls[4] = 1'b1;
        dec.rdid   = '0;
        dec.imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec.cls[5] = 1'b1;
        dec.rdwen  = 1'b1;
        dec.rs1id  = '0;
        dec.rs2id  = '0;
        dec.imm    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.cls[7] = (ins[6:0] == OPC_LUI);
        dec.cls[8] = (ins[6:0] == OPC_AUIPC);
        dec.rdwen  = 1'b1;
        dec.rs1id  = '0;
        dec.rs2id  = '0;
        dec.imm    = {ins[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        dec.cls[9] = 1'b1;
        dec.rs2id  = '0;
        // CSR forms write rd only when it is a real register.
        dec.rdwen  = (ins[14:12] != 3'b000) && (ins[11:7] != 5'd0);
        dec.imm    = {27'b0, ins[19:15]};
        dec.ecall  = (ins[31:7] == 25'd0);
        dec.mret   = (ins[31:0] == 32'h3020_0073);
      end
      default: begin
        // Unknown opcodes still flow through, flagged and inert.
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    out_d = out_q;
    if (bus.i_flush) begin
      vld_d = 1'b0;
    end else if (pop) begin
      vld_d = 1'b1;
      out_d = dec;
    end else if (bus.i_post_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
    end
  end

  assign bus.o_pre_ready  = pre_ready;
  assign bus.o_post_valid = vld_q;
  assign bus.o_count      = cnt_q;
  assign bus.o_pc         = out_q.pc;
  assign bus.o_rdid       = out_q.rdid;
  assign bus.o_rs1id      = out_q.rs1id;
  assign bus.o_rs2id      = out_q.rs2id;
  assign bus.o_rdwen      = out_q.rdwen;
  assign bus.o_imm        = out_q.imm;
  assign bus.o_cls        = out_q.cls;
  assign bus.o_funct3     = out_q.funct3;
  assign bus.o_f7b5       = out_q.f7b5;
  assign bus.o_ecall      = out_q.ecall;
  assign bus.o_mret       = out_q.mret;
  assign bus.o_illegal    = out_q.illegal;
endmodule

// File: tb/tb_idu_q.sv
// Directed bench for idu_q: expected decode records are queued when an
// instruction is accepted and compared when the stage hands one downstream.
module tb_idu_q;
  logic clk;
  logic rst;

  idu_q_if #(.DEPTH(4)) bus ();
  idu_q #(.DEPTH(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [31:0] imm;
    logic [9:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic        ec;
    logic        mr;
    logic        il;
  } rec_t;

  rec_t sb[$];
  rec_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  bit   last_push;

  function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic we, input logic [31:0] imm,
                              input logic [9:0] cls, input logic [2:0] f3,
                              input logic f7, input logic ec, input logic mr,
                              input logic il);
    rec_t r;
    r.pc = pc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.we = we; r.imm = imm;
    r.cls = cls; r.f3 = f3; r.f7 = f7; r.ec = ec; r.mr = mr; r.il = il;
    return r;
  endfunction

  function automatic rec_t dut_rec();
    return mk(bus.o_pc, bus.o_rdid, bus.o_rs1id, bus.o_rs2id, bus.o_rdwen,
              bus.o_imm, bus.o_cls, bus.o_funct3, bus.o_f7b5, bus.o_ecall,
              bus.o_mret, bus.o_illegal);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input rec_t exp);
    bus.i_pre_valid = 1'b1;
    bus.i_pc        = pc;
    bus.i_instr     = ins;
    cur_exp         = exp;
  endtask

  task automatic idle();
    bus.i_pre_valid = 1'b0;
  endtask

  // One clock: observe handshakes mid-cycle, then step past the rising edge.
  task automatic tick();
    rec_t exp;
    @(negedge clk);
    if (bus.o_post_valid && bus.i_post_ready) begin
      chk("out_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("out_data", 128'(dut_rec()), 128'(exp));
      end
      n_out++;
    end
    last_push = 1'b0;
    if (bus.i_flush) begin
      sb.delete();
    end else if (bus.i_pre_valid && bus.o_pre_ready) begin
      sb.push_back(cur_exp);
      last_push = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  function automatic rec_t addi_rec(input logic [31:0] pc, input int k);
    return mk(pc, 5'd1, 5'd0, 5'd0, 1'b1, 32'(k), 10'h002, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  initial begin
    int base;
    int idx;
    int cyc;
    rst = 1'b1;
    bus.i_pre_valid  = 1'b0;
    bus.i_pc         = '0;
    bus.i_instr      = '0;
    bus.i_flush      = 1'b0;
    bus.i_post_ready = 1'b0;
    #1;
    chk("rst_valid", 128'(bus.o_post_valid), 128'(0));
    chk("rst_count", 128'(bus.o_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 128'(bus.o_pre_ready), 128'(1));
    chk("rst_outs", 128'({bus.o_pc, bus.o_imm, bus.o_cls, bus.o_rdwen}), 128'(0));

    // Basic decode and two-cycle latency
    bus.i_post_ready = 1'b1;
    drive(32'h8000_0000, 32'h0050_0093,
          mk(32'h8000_0000, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5, 10'h002, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    idle();
    chk("lat_n1_valid", 128'(bus.o_post_valid), 128'(0));
    tick();
    chk("lat_n2_valid", 128'(bus.o_post_valid), 128'(1));
    chk("basic_fields", 128'({bus.o_rdid, bus.o_rs1id, bus.o_imm, bus.o_cls, bus.o_rdwen, bus.o_pc}),
        128'({5'd1, 5'd0, 32'd5, 10'h002, 1'b1, 32'h8000_0000}));
    tick();
    chk("basic_drained", 128'(bus.o_post_valid), 128'(0));

    // Store, branch, lui, system and illegal at full rate
    base = n_out;
    drive(32'h100, 32'h0011_2623, mk(32'h100, 5'd0, 5'd2, 5'd1, 1'b0, 32'd12, 10'h008, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    drive(32'h104, 32'hFE00_0EE3, mk(32'h104, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFC, 10'h010, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(32'h108, 32'h1234_52B7, mk(32'h108, 5'd5, 5'd0, 5'd0, 1'b1, 32'h1234_5000, 10'h080, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    drive(32'h10C, 32'h0000_0073, mk(32'h10C, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 10'h200, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    drive(32'h110, 32'h3020_0073, mk(32'h110, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 10'h200, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    drive(32'h114, 32'h0000_007F, mk(32'h114, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 10'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    drive(32'h118, 32'h0000_0093, addi_rec(32'h118, 0));
    tick();
    idle();
    chk("rate_outputs", 128'(n_out - base), 128'(5));
    drain("rate_drain", 10);

    // Back-pressure: 8 offered with downstream stalled
    bus.i_post_ready = 1'b0;
    base = n_out;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 8) drive(32'h2000 + 32'(4 * idx), addi_k(idx + 1), addi_rec(32'h2000 + 32'(4 * idx), idx + 1));
      tick();
      if (last_push) idx++;
    end
    chk("bp_accepted", 128'(idx), 128'(5));
    chk("bp_ready", 128'(bus.o_pre_ready), 128'(0));
    chk("bp_count", 128'(bus.o_count), 128'(4));
    chk("bp_valid", 128'(bus.o_post_valid), 128'(1));
    chk("bp_head_held", 128'({bus.o_pc, bus.o_imm}), 128'({32'h2000, 32'd1}));
    bus.i_post_ready = 1'b1;
    cyc = 0;
    while ((idx < 8 || sb.size() != 0) && cyc < 60) begin
      if (idx < 8) drive(32'h2000 + 32'(4 * idx), addi_k(idx + 1), addi_rec(32'h2000 + 32'(4 * idx), idx + 1));
      else idle();
      tick();
      if (last_push) idx++;
      cyc++;
    end
    idle();
    chk("bp_all_out", 128'(n_out - base), 128'(8));
    chk("bp_sb_empty", 128'(sb.size()), 128'(0));

    // Flush with three queued plus one registered, push on the same cycle
    bus.i_post_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'h3000 + 32'(4 * k), addi_k(20 + k), addi_rec(32'h3000 + 32'(4 * k), 20 + k));
      tick();
    end
    idle();
    chk("fl_pre_count", 128'(bus.o_count), 128'(3));
    chk("fl_pre_valid", 128'(bus.o_post_valid), 128'(1));
    bus.i_flush = 1'b1;
    drive(32'hDEAD_0000, addi_k(99), addi_rec(32'hDEAD_0000, 99));
    tick();
    bus.i_flush = 1'b0;
    idle();
    chk("fl_count", 128'(bus.o_count), 128'(0));
    chk("fl_valid", 128'(bus.o_post_valid), 128'(0));
    chk("fl_ready", 128'(bus.o_pre_ready), 128'(1));
    bus.i_post_ready = 1'b1;
    base = n_out;
    repeat (4) tick();
    chk("fl_no_output", 128'(n_out - base), 128'(0));
    drive(32'h3100, addi_k(7), addi_rec(32'h3100, 7));
    tick();
    idle();
    drain("fl_recover", 10);

    // Asynchronous reset with two entries queued
    bus.i_post_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h4000 + 32'(4 * k), addi_k(30 + k), addi_rec(32'h4000 + 32'(4 * k), 30 + k));
      tick();
    end
    idle();
    chk("rs_pre_count", 128'(bus.o_count), 128'(2));
    #2 rst = 1'b1;
    #1;
    chk("rs_valid_async", 128'(bus.o_post_valid), 128'(0));
    chk("rs_count_async", 128'(bus.o_count), 128'(0));
    sb.delete();
    #1 rst = 1'b0;
    tick();
    chk("rs_ready", 128'(bus.o_pre_ready), 128'(1));
    bus.i_post_ready = 1'b1;
    drive(32'h5000, addi_k(42), addi_rec(32'h5000, 42));
    tick();
    idle();
    chk("rs_lat_n1", 128'(bus.o_post_valid), 128'(0));
    tick();
    chk("rs_lat_n2", 128'(bus.o_post_valid), 128'(1));
    drain("rs_drain", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/idu_q.md
# idu_q

Queued, registered instruction-decode stage. Incoming `{pc, instr}` pairs are buffered in a parametrised FIFO. The FIFO head is decoded into register ids, a sign-extended immediate, a one-hot instruction class and system flags, and the result is held in an elastic output register. It sits between IFU and EXU, and replaces pass-through handshaking with real buffering, back-pressure and flush.

## Interface
- `INS_WIDTH`, 32: instruction width; fixed at 32 for RV32I encodings.
- `PC_WIDTH`, 32: width of the PC carried alongside each instruction.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width.

Ports (reset is asynchronous and active-high):
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_pre_valid` in 1: upstream holds a valid instruction.
- `o_pre_ready` out 1: stage can accept an instruction.
- `i_pc` in PC_WIDTH: PC of the incoming instruction.
- `i_instr` in INS_WIDTH: incoming instruction.
- `i_flush` in 1: discard all queued and registered instructions.
- `o_post_valid` out 1: decoded output is valid.
- `i_post_ready` in 1: downstream accepts the decoded output.
- `o_pc` out PC_WIDTH: PC of the decoded instruction.
- `o_rdid`, `o_rs1id`, `o_rs2id` out 5 each: register ids.
- `o_rdwen` out 1: rd write enable.
- `o_imm` out 32: immediate.
- `o_cls` out 10: one-hot class: [0] OP, [1] OP-IMM, [2] LOAD, [3] STORE, [4] BRANCH, [5] JAL, [6] JALR, [7] LUI, [8] AUIPC, [9] SYSTEM.
- `o_funct3` out 3: `instr[14:12]`.
- `o_f7b5` out 1: `instr[30]`.
- `o_ecall`, `o_mret`, `o_illegal` out 1 each: system and illegal-opcode flags.
- `o_count` out CNT_W: FIFO occupancy. The output register is not counted.

## Operation
**FIFO**
- Write pointer, read pointer and count.
- Push when `i_pre_valid & o_pre_ready & !i_flush`.
- Pop when the FIFO is non-empty and `(!o_post_valid | i_post_ready) & !i_flush`.
- `o_pre_ready = (count != DEPTH)`, computed from the registered count only. When full, no push occurs even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves the count unchanged.

**Decode** (combinational on the FIFO head; registered on pop)
- `rdid = instr[11:7]`, `rs1id = instr[19:15]`, `rs2id = instr[24:20]`.
- For STORE and BRANCH, `rdid = 0`.
- For LUI, JAL and AUIPC, `rs1id = 0` and `rs2id = 0`.
- For OP-IMM, LOAD, JALR and SYSTEM, `rs2id = 0`.
- Immediates:
  - I-type (OP-IMM, LOAD, JALR): `sext(instr[31:20])`.
  - S-type: `sext({instr[31:25], instr[11:7]})`.
  - B-type: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})`.
  - U-type: `{instr[31:12], 12'b0}`.
  - J-type: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})`.
  - SYSTEM: `{27'b0, instr[19:15]}` (zimm).
  - OP: 0.
- `rdwen = 1` for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC.
- For SYSTEM, `rdwen = 1` when `funct3 != 0 && rdid != 0`.
- `ecall = SYSTEM && instr[31:7] == 0`.
- `mret` when `instr == 0x30200073`.
- Unknown opcode:
  - `o_cls = 0`, `o_illegal = 1`, `o_rdwen = 0`, `o_imm = 0`.
  - The instruction still flows through the stage.

**Output register**
- Loads decode results and `o_pc` on pop and sets `o_post_valid`.
- Clears `o_post_valid` when `o_post_valid & i_post_ready` and no pop occurs.
- Data is held stable while `o_post_valid & !i_post_ready`.

**Flush**
- Next cycle: count 0, pointers 0, `o_post_valid = 0`.
- A same-cycle push is dropped.
- A same-cycle downstream handshake is still considered completed.

**Reset** (including mid-operation)
- Pointers and count are 0.
- All output-register fields are 0 and `o_post_valid = 0`.
- `o_pre_ready` is 1 once reset is released; `o_count = 0`.

## Timing
- Latency: push at edge N, head visible in cycle N+1, output register loads at edge N+1, so `o_post_valid` is high in cycle N+2.
- Throughput: 1 instruction/cycle sustained when `i_post_ready` is held high.
- Capacity under full back-pressure: DEPTH + 1 instructions, i.e. FIFO plus output register.
- `o_pre_ready` depends only on state, with no combinational path from `i_post_ready`. `o_post_valid` and all output data are registered.
- Flush takes effect at the next edge. `o_pre_ready` is 1 in the cycle after a flush.

## Test plan
- **Basic decode.** Push `0x00500093` (`addi x1,x0,5`) at pc `0x80000000`, with `i_post_ready = 1`.
  - Two cycles later: `o_rdid = 1`, `o_rs1id = 0`, `o_imm = 5`, `o_cls = 0x002`, `o_rdwen = 1`, `o_pc = 0x80000000`.
- **Store and branch.** Push `0x00112623` (`sw x1,12(x2)`).
  - Required: `rs1 = 2`, `rs2 = 1`, `rd = 0`, `imm = 12`, `cls = 0x008`, `rdwen = 0`.
  - Push `0xFE000EE3` (`beq x0,x0,-4`). Required: `imm = 0xFFFFFFFC`, `cls = 0x010`.
- **System and illegal opcodes.**
  - `0x00000073`: `ecall = 1`, `cls = 0x200`, `rdwen = 0`.
  - `0x30200073`: `mret = 1`.
  - `0x0000007F`: `illegal = 1`, `cls = 0`, `rdwen = 0`.
- **Back-pressure with DEPTH = 4.** Hold `i_post_ready = 0` and stream 8 instructions.
  - Exactly 5 are accepted, then `o_pre_ready = 0` and `o_count = 4`.
  - Release `i_post_ready`. All 8 instructions emerge in order, with unchanged data and no duplicates.
- **Flush.** With `o_count = 3` and `o_post_valid = 1`, assert `i_flush` together with `i_pre_valid`.
  - Next cycle: `o_count = 0`, `o_post_valid = 0`, and the pushed instruction never appears.
- **Reset mid-stream.** Assert `i_rst` asynchronously while `o_count = 2`.
  - Required: `o_post_valid = 0` and `o_count = 0` immediately, with no clock edge.
  - After release, the first new push emerges 2 cycles later.
